// File: rtl/ld3320_reg_sequencer.sv
// LD3320 register command sequencer.
// Walks a WRITE / POLL / DELAY / END command table and issues one-cycle
// transactions to the LD3320 parallel-bus engine, spacing them to the
// engine's fixed IDLE->...->IDLE round trip.
// Optional feature: define LD3320_SEQ_READBACK_EN to read back every WRITE
// and abort on a mismatch.
module ld3320_reg_sequencer #(
  parameter int IDX_W      = 6,
  parameter int BUS_GAP    = 5,
  parameter int RD_TIMEOUT = 8,
  parameter int DELAY_UNIT = 1000,
  parameter int POLL_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [17:0]      tbl_entry,
  output logic             bus_ena,
  output logic             bus_sel,
  output logic [7:0]       bus_addr,
  output logic [7:0]       bus_data,
  input  logic [7:0]       bus_rdata,
  input  logic             bus_rready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       last_rdata
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_POLL  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  localparam int ATT_W = $clog2(POLL_LIMIT + 1);
  localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);

  // Cycles-since-bus_ena thresholds. Leaving through FETCH costs one extra
  // cycle before the next ISSUE, hence GAP-2 versus GAP-1 for a direct reissue.
  localparam logic [7:0]       GAP_FETCH = 8'(BUS_GAP - 2);
  localparam logic [7:0]       GAP_ISSUE = 8'(BUS_GAP - 1);
  localparam logic [7:0]       TO_LAST   = 8'(RD_TIMEOUT - 1);
  localparam logic [ATT_W-1:0] POLL_MAX  = ATT_W'(POLL_LIMIT);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_WR, S_WAIT_RD, S_EVAL, S_DELAY, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [17:0]      entry_q, entry_d;
  logic [7:0]       txn_q, txn_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             do_adv;
  logic             gap_fetch;
  logic [7:0]       arg;

`ifdef LD3320_SEQ_READBACK_EN
  logic rb_q, rb_d;
`else
  logic rb_q;
  assign rb_q = 1'b0;
`endif

  assign arg       = entry_q[7:0];
  assign gap_fetch = (txn_q >= GAP_FETCH);

  // Next-state, table walk and counter logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    txn_d   = (txn_q == 8'hFF) ? txn_q : txn_q + 8'd1;
    dly_d   = dly_q;
    att_d   = att_q;
    rdata_d = rdata_q;
    do_adv  = 1'b0;
`ifdef LD3320_SEQ_READBACK_EN
    rb_d    = rb_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          att_d   = '0;
        end
      end
      S_FETCH: begin
        entry_d = tbl_entry;
`ifdef LD3320_SEQ_READBACK_EN
        rb_d    = 1'b0;
`endif
        case (tbl_entry[17:16])
          OP_END:   state_d = S_DONE;
          OP_DELAY: begin
            state_d = S_DELAY;
            dly_d   = DLY_W'(tbl_entry[7:0]) * DLY_W'(DELAY_UNIT);
          end
          default:  state_d = S_ISSUE;
        endcase
      end
      S_ISSUE: begin
        txn_d = 8'd1;
        if (entry_q[17:16] == OP_POLL) begin
          att_d   = att_q + ATT_W'(1);
          state_d = S_WAIT_RD;
        end else if (rb_q) begin
          state_d = S_WAIT_RD;
        end else begin
          state_d = S_WAIT_WR;
        end
      end
      S_WAIT_WR: begin
`ifdef LD3320_SEQ_READBACK_EN
        if (txn_q >= GAP_ISSUE) begin
          rb_d    = 1'b1;
          state_d = S_ISSUE;
        end
`else
        if (gap_fetch) do_adv = 1'b1;
`endif
      end
      S_WAIT_RD: begin
        if (bus_rready) begin
          rdata_d = bus_rdata;
          state_d = S_EVAL;
        end else if (txn_q >= TO_LAST) begin
          state_d = S_ERR;
        end
      end
      S_EVAL: begin
        if (rb_q) begin
          if (rdata_q == arg) begin
            if (gap_fetch) do_adv = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end else if ((rdata_q & arg) == arg) begin
          if (gap_fetch) do_adv = 1'b1;
        end else if (att_q >= POLL_MAX) begin
          state_d = S_ERR;
        end else if (txn_q >= GAP_ISSUE) begin
          state_d = S_ISSUE;
        end
      end
      S_DELAY: begin
        if (dly_q <= DLY_W'(1)) do_adv = 1'b1;
        else                    dly_d  = dly_q - DLY_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The last table slot must hold END; running past it aborts instead of wrapping.
    if (do_adv) begin
      att_d = '0;
      if (idx_q == '1) begin
        state_d = S_ERR;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = S_FETCH;
      end
    end

    err_d = err_q;
    if (state_q == S_IDLE && start) err_d = 1'b0;
    if (state_d == S_ERR)           err_d = 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      entry_q <= '0;
      txn_q   <= '0;
      dly_q   <= '0;
      att_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef LD3320_SEQ_READBACK_EN
      rb_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      entry_q <= entry_d;
      txn_q   <= txn_d;
      dly_q   <= dly_d;
      att_q   <= att_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef LD3320_SEQ_READBACK_EN
      rb_q    <= rb_d;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign tbl_idx    = idx_q;
  assign bus_ena    = (state_q == S_ISSUE);
  assign bus_sel    = busy && (entry_q[17:16] == OP_WRITE) && !rb_q;
  assign bus_addr   = entry_q[15:8];
  assign bus_data   = entry_q[7:0];
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign last_rdata = rdata_q;

endmodule

// File: tb/tb_ld3320_reg_sequencer.sv
// Testbench for ld3320_reg_sequencer: directed command tables, a small bus
// engine model and a scoreboard of expected bus transactions.
module tb_ld3320_reg_sequencer;

  localparam int IDX_W = 3;
  localparam int GAP   = 5;
  localparam int RDTO  = 8;

  logic             clk, rst, start;
  logic [IDX_W-1:0] tbl_idx;
  logic [17:0]      tbl_entry;
  logic             bus_ena, bus_sel;
  logic [7:0]       bus_addr, bus_data, bus_rdata;
  logic             bus_rready;
  logic             busy, done, err;
  logic [7:0]       last_rdata;

  logic [17:0] tbl [0:7];
  assign tbl_entry = tbl[tbl_idx];

  ld3320_reg_sequencer #(
    .IDX_W(IDX_W), .BUS_GAP(GAP), .RD_TIMEOUT(RDTO), .DELAY_UNIT(10), .POLL_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tbl_idx(tbl_idx), .tbl_entry(tbl_entry),
    .bus_ena(bus_ena), .bus_sel(bus_sel), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_rdata(bus_rdata), .bus_rready(bus_rready), .busy(busy), .done(done),
    .err(err), .last_rdata(last_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  // Scoreboard: expected {sel, addr, data}; for reads only {sel, addr} is checked.
  logic [16:0] exp_q [$];
  int          ena_times [$];
  int          n_ena = 0;
  bit          prev_ena = 1'b0;

  // Bus engine model: data_ready three cycles after a read bus_ena.
  logic [7:0] resp_q [$];
  bit         withhold = 1'b0;
  bit         spur = 1'b0;
  int         rr_cd = 0;

  always @(negedge clk) begin
    bus_rready = 1'b0;
    if (rr_cd > 0) begin
      rr_cd--;
      if (rr_cd == 0 && !withhold) begin
        bus_rready = 1'b1;
        bus_rdata  = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
      end
    end
    if (bus_ena && !bus_sel) rr_cd = 3;
    if (spur) begin
      bus_rready = 1'b1;
      bus_rdata  = 8'hEE;
    end
  end

  // Monitor: compare every bus transaction against the scoreboard.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) begin
      prev_ena = 1'b0;
    end else begin
      if (bus_ena) begin
        n_ena++;
        ena_times.push_back(cyc);
        chk("ena_one_cycle", {31'd0, prev_ena}, 32'd0);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_bus_ena: got sel=%0d addr=0x%0h expected none", bus_sel, bus_addr);
        end else begin
          e = exp_q.pop_front();
          if (e[16]) chk("bus_write_txn", {15'd0, bus_sel, bus_addr, bus_data}, {15'd0, e});
          else       chk("bus_read_txn", {23'd0, bus_sel, bus_addr}, {23'd0, e[16:8]});
        end
      end
      prev_ena = bus_ena;
    end
  end

  function automatic logic [17:0] ent(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    return {op, a, d};
  endfunction

  function automatic int ena_at(input int i);
    return (ena_times.size() > i) ? ena_times[i] : -1000;
  endfunction

  task automatic clear_tbl();
    for (int i = 0; i < 8; i++) tbl[i] = 18'h3_0000;
    n_ena = 0;
    ena_times.delete();
    resp_q.delete();
    withhold = 1'b0;
  endtask

  task automatic start_seq(output int f);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f = cyc;
  endtask

  task automatic wait_end(input string nm, output int e, output bit gd, output bit ge);
    gd = 1'b0;
    ge = 1'b0;
    e  = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin gd = 1'b1; e = cyc; break; end
      if (err)  begin ge = 1'b1; e = cyc; break; end
    end
    if (!gd && !ge) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done/err expected one within 300 cycles", nm);
    end
  endtask

  task automatic end_test(input string nm);
    repeat (3) @(negedge clk);
    chk({nm, "_exp_left"}, exp_q.size(), 0);
    chk({nm, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin
    int  f, e;
    bit  gd, ge;
    rst = 1'b1;
    start = 1'b0;
    bus_rdata = 8'h00;
    bus_rready = 1'b0;
    clear_tbl();
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {bus_ena, bus_sel, bus_addr, bus_data, busy, done, err, last_rdata, 1'b0, tbl_idx},
        32'd0);
    rst = 1'b0;

    // 1: single write then END
    clear_tbl();
    tbl[0] = ent(2'b00, 8'h17, 8'h35);
    exp_q.push_back({1'b1, 8'h17, 8'h35});
    start_seq(f);
    wait_end("t1", e, gd, ge);
    chk("t1_done", gd, 1);
    chk("t1_err", err, 0);
    chk("t1_ena_count", n_ena, 1);
    chk("t1_done_by_gap_plus_2", (ena_at(0) >= 0) && (e - ena_at(0) <= GAP + 2), 1);
    @(negedge clk);
    chk("t1_done_one_cycle", done, 0);
    end_test("t1");

    // 2: back-to-back writes exactly GAP apart
    clear_tbl();
    tbl[0] = ent(2'b00, 8'h05, 8'h01);
    tbl[1] = ent(2'b00, 8'h06, 8'h02);
    exp_q.push_back({1'b1, 8'h05, 8'h01});
    exp_q.push_back({1'b1, 8'h06, 8'h02});
    start_seq(f);
    wait_end("t2", e, gd, ge);
    chk("t2_done", gd, 1);
    chk("t2_ena_count", n_ena, 2);
    chk("t2_ena_spacing", ena_at(1) - ena_at(0), GAP);
    end_test("t2");

    // 3: poll B2 mask 21, matches on third read
    clear_tbl();
    tbl[0] = ent(2'b01, 8'hB2, 8'h21);
    resp_q.push_back(8'h00);
    resp_q.push_back(8'h20);
    resp_q.push_back(8'h21);
    repeat (3) exp_q.push_back({1'b0, 8'hB2, 8'h21});
    start_seq(f);
    wait_end("t3", e, gd, ge);
    chk("t3_done", gd, 1);
    chk("t3_read_count", n_ena, 3);
    chk("t3_last_rdata", last_rdata, 8'h21);
    chk("t3_retry_spacing", ena_at(2) - ena_at(1), GAP);
    end_test("t3");

    // Spurious data_ready while idle is ignored
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spurious_rready_last_rdata", last_rdata, 8'h21);
    chk("spurious_rready_busy", busy, 0);

    // 4: poll never matches, limit 4
    clear_tbl();
    tbl[0] = ent(2'b01, 8'h10, 8'h80);
    repeat (4) exp_q.push_back({1'b0, 8'h10, 8'h80});
    start_seq(f);
    wait_end("t4", e, gd, ge);
    chk("t4_err", ge, 1);
    chk("t4_no_done", gd, 0);
    chk("t4_read_count", n_ena, 4);
    chk("t4_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("t4_err_held", err, 1);
    chk("t4_exp_left", exp_q.size(), 0);

    // 5: read timeout at entry 1, then rerun clears err and restarts at 0
    clear_tbl();
    tbl[0] = ent(2'b00, 8'h30, 8'hAA);
    tbl[1] = ent(2'b01, 8'h20, 8'h01);
    withhold = 1'b1;
    exp_q.push_back({1'b1, 8'h30, 8'hAA});
    exp_q.push_back({1'b0, 8'h20, 8'h01});
    start_seq(f);
    wait_end("t5a", e, gd, ge);
    chk("t5_err", ge, 1);
    chk("t5_err_latency", e - ena_at(1), RDTO);
    chk("t5_idx_at_err", tbl_idx, 1);
    repeat (3) @(negedge clk);
    withhold = 1'b0;
    n_ena = 0;
    ena_times.delete();
    resp_q.push_back(8'h01);
    exp_q.push_back({1'b1, 8'h30, 8'hAA});
    exp_q.push_back({1'b0, 8'h20, 8'h01});
    start_seq(f);
    chk("t5_err_cleared", err, 0);
    chk("t5_restart_idx", tbl_idx, 0);
    chk("t5_busy_after_start", busy, 1);
    wait_end("t5b", e, gd, ge);
    chk("t5_rerun_done", gd, 1);
    chk("t5_rerun_rdata", last_rdata, 8'h01);
    end_test("t5");

    // 6: DELAY 3 x 10 cycles: FETCH + 30 DELAY + FETCH before the write issues
    clear_tbl();
    tbl[0] = ent(2'b10, 8'h00, 8'h03);
    tbl[1] = ent(2'b00, 8'h40, 8'h55);
    exp_q.push_back({1'b1, 8'h40, 8'h55});
    start_seq(f);
    wait_end("t6a", e, gd, ge);
    chk("t6_done", gd, 1);
    chk("t6_delay_gap", ena_at(0) - f, 32);
    end_test("t6a");

    // rst in the middle of a DELAY at entry 1
    clear_tbl();
    tbl[0] = ent(2'b00, 8'h40, 8'h55);
    tbl[1] = ent(2'b10, 8'h00, 8'h03);
    exp_q.push_back({1'b1, 8'h40, 8'h55});
    start_seq(f);
    repeat (14) @(negedge clk);
    chk("t6_in_delay", {busy, 1'b0, tbl_idx}, {1'b1, 1'b0, 3'd1});
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_outputs",
        {bus_ena, bus_sel, bus_addr, bus_data, busy, done, err, last_rdata, 1'b0, tbl_idx},
        32'd0);
    rst = 1'b0;
    end_test("t6b");

    // 7: table with no END runs off the last slot
    clear_tbl();
    for (int i = 0; i < 8; i++) begin
      tbl[i] = ent(2'b00, 8'h80 + 8'(i), 8'(i));
      exp_q.push_back({1'b1, 8'h80 + 8'(i), 8'(i)});
    end
    start_seq(f);
    wait_end("t7", e, gd, ge);
    chk("t7_overrun_err", ge, 1);
    chk("t7_no_done", gd, 0);
    chk("t7_write_count", n_ena, 8);
    chk("t7_idx", tbl_idx, 7);
    repeat (3) @(negedge clk);
    chk("t7_exp_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ld3320_reg_sequencer.md
Name: ld3320_reg_sequencer

Overview:
- Command sequencer directly upstream of the LD3320 parallel-bus write/read engine.
- Walks an external command table of WRITE / POLL / DELAY / END entries and turns each into one-cycle bus transactions (bus_ena, bus_sel, bus_addr, bus_data) for the engine.
- Times each write to the engine's fixed state sequence and captures read data on the engine's data_ready strobe.
- Used for LD3320 chip init and recognition start-up sequences.

Parameters:
- IDX_W, 6, table index width; the table holds 2^IDX_W entries.
- BUS_GAP, 5, minimum cycles from one bus_ena pulse to the next; matches the engine's IDLE→IDLE round trip.
- RD_TIMEOUT, 8, cycles after a read bus_ena within which bus_rready must arrive.
- DELAY_UNIT, 1000, clock cycles per DELAY count.
- POLL_LIMIT, 255, maximum read attempts per POLL entry.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin sequence at entry 0; ignored while busy
- tbl_idx  out  IDX_W  table read index
- tbl_entry  in  18  combinational table data for tbl_idx: [17:16] op, [15:8] addr, [7:0] arg
- bus_ena  out  1  one-cycle transaction request to the bus engine
- bus_sel  out  1  1 = write, 0 = read
- bus_addr  out  8  register address
- bus_data  out  8  write data
- bus_rdata  in  8  engine data_valid
- bus_rready  in  1  engine data_ready strobe
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when an END entry is reached
- err  out  1  level; sequence aborted (timeout, poll limit, table overrun)
- last_rdata  out  8  most recent captured read value

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; tbl_idx 0.
- Op encoding: 00 WRITE addr←arg; 01 POLL read addr until (rdata & arg) == arg; 10 DELAY arg*DELAY_UNIT cycles; 11 END.
- States: IDLE, FETCH, ISSUE, WAIT_WR, WAIT_RD, EVAL, DELAY, DONE, ERR.
- IDLE:
  - start=1 → FETCH, tbl_idx=0, busy=1 from the next cycle, err cleared.
  - start is ignored in every other state.
- FETCH: register tbl_entry.
  - END → DONE.
  - DELAY → DELAY.
  - WRITE/POLL → ISSUE.
- ISSUE: drive bus_ena=1 for exactly one cycle. bus_addr, bus_data and bus_sel are held stable from ISSUE until the transaction ends.
  - WRITE → WAIT_WR.
  - POLL → WAIT_RD; the poll attempt counter increments.
- WAIT_WR: wait until BUS_GAP cycles have elapsed since the bus_ena cycle, then advance.
  - The engine does IDLE→ADDR_WR→ADDR_WR_DONE→DATA_WR→DATA_WR_DONE→IDLE.
  - Next bus_ena is therefore never earlier than bus_ena cycle + BUS_GAP.
- WAIT_RD: bus_rready is expected 3 cycles after bus_ena.
  - On bus_rready=1, capture bus_rdata into last_rdata → EVAL.
  - No bus_rready within RD_TIMEOUT cycles → ERR.
- EVAL:
  - Match → advance.
  - No match, attempts < POLL_LIMIT → ISSUE, after BUS_GAP has elapsed since the previous bus_ena.
  - No match, attempts == POLL_LIMIT → ERR.
- DELAY: count arg*DELAY_UNIT cycles, then advance. arg=0 advances on the next cycle.
- Advance:
  - tbl_idx+1 → FETCH; the poll attempt counter clears.
  - If tbl_idx == 2^IDX_W−1 and the entry was not END → ERR (no wrap).
- DONE: done=1 for one cycle, busy=0 → IDLE.
- ERR: err=1 (held until the next accepted start), busy=0 → IDLE.
- A spurious bus_rready outside WAIT_RD is ignored.
- rst mid-sequence: the next cycle is IDLE with all outputs 0. The engine completes its current transaction on its own.

Optional Feature:
- Macro LD3320_SEQ_READBACK_EN.
- Defined:
  - Each WRITE is followed, after BUS_GAP, by a read of the same address.
  - The result goes to last_rdata.
  - Mismatch against arg → ERR; match → advance.
  - Timeout rules are as in WAIT_RD.
- Undefined: writes are unverified and the readback logic is absent.

Test Plan:
1. Table {WRITE 0x17←0x35, END}; pulse start → one bus_ena with sel=1, addr=0x17, data=0x35; done pulses at bus_ena+BUS_GAP+2 or earlier; err=0.
2. Back-to-back WRITEs 0x05←0x01, 0x06←0x02, END → bus_ena pulses exactly BUS_GAP cycles apart; each pulse is one cycle wide.
3. POLL addr 0xB2, mask 0x21; model returns 0x00, 0x20, 0x21 → three reads, last_rdata=0x21, then advance; done=1.
4. POLL where the model never matches, POLL_LIMIT=4 → exactly 4 reads, then err=1, busy=0, no done.
5. Model withholds bus_rready → err at bus_ena+RD_TIMEOUT; a following start clears err and reruns from index 0.
6. DELAY arg=3 with DELAY_UNIT=10 → 30-cycle gap before the next entry. Assert rst mid-DELAY → busy=0 and tbl_idx=0 on the next cycle.
